// File: rtl/lsu_arb_pkg.sv
// Shared types, funct3 encodings and the access-legality check used by the LSU arbiter.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have signed widths; loads add the two unsigned variants.
  function automatic logic is_access_err(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic bad_f3;
    logic misal;
    if (we) bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
            ((funct3[1:0] == 2'b01) && addr_lo[0]);
    return bad_f3 | misal;
  endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Two-way winner picker: round-robin via a priority flop, or fixed priority to requester 0.
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       winner_o,
  output logic       any_req_o
);

  logic r_prio;

  always_comb begin
    any_req_o = |req_i;
    if (req_i == 2'b11) winner_o = (FIXED_PRIO != 0) ? 1'b0 : r_prio;
    else                winner_o = req_i[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             r_prio <= 1'b0;
    else if ((FIXED_PRIO == 0) && accept_i)  r_prio <= ~winner_o;
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-requester front end for the shared LSU: grant, one-cycle LSU access, registered response.
//
// state  | meaning
// IDLE   | no transaction in flight
// ACCESS | LSU driven from the latched request
// RESP   | response presented to the owner; a new request may be accepted
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [2:0]        m0_funct3_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m0_err_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [2:0]        m1_funct3_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic              m1_err_o,
  output logic [31:0]       m1_rdata_o,
  output logic              lsu_wren_o,
  output logic [2:0]        lsu_funct3_o,
  output logic [ADDR_W-1:0] lsu_addr_o,
  output logic [31:0]       lsu_st_data_o,
  input  logic [31:0]       lsu_ld_data_i
);

  state_e            r_state, w_state_nxt;
  logic              r_owner, r_we, r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic              w_winner, w_any_req, w_accept, w_err_det, w_resp;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     ({m1_req_i, m0_req_i}),
    .accept_i  (w_accept),
    .winner_o  (w_winner),
    .any_req_o (w_any_req)
  );

  assign w_err_det = is_access_err(r_we, r_f3, r_addr[1:0]);

  always_comb begin
    w_state_nxt = IDLE;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        w_accept    = w_any_req;
        w_state_nxt = w_any_req ? ACCESS : IDLE;
      end
      ACCESS:  w_state_nxt = RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      if (w_accept) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? m1_we_i     : m0_we_i;
        r_f3    <= w_winner ? m1_funct3_i : m0_funct3_i;
        r_addr  <= w_winner ? m1_addr_i   : m0_addr_i;
        r_wdata <= w_winner ? m1_wdata_i  : m0_wdata_i;
      end
      if (r_state == ACCESS) begin
        r_err   <= w_err_det;
        r_rdata <= (!r_we && !w_err_det) ? lsu_ld_data_i : 32'h0;
      end
    end
  end

  assign m0_gnt_o = w_accept & ~w_winner;
  assign m1_gnt_o = w_accept &  w_winner;

  assign w_resp      = (r_state == RESP);
  assign m0_rvalid_o = w_resp & ~r_owner;
  assign m1_rvalid_o = w_resp &  r_owner;
  assign m0_err_o    = m0_rvalid_o & r_err;
  assign m1_err_o    = m1_rvalid_o & r_err;
  assign m0_rdata_o  = m0_rvalid_o ? r_rdata : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? r_rdata : 32'h0;

  // LSU fields stay on the latched values so the address is stable between accesses.
  assign lsu_wren_o    = (r_state == ACCESS) & r_we & ~w_err_det;
  assign lsu_funct3_o  = r_f3;
  assign lsu_addr_o    = r_addr;
  assign lsu_st_data_o = r_wdata;

endmodule

// File: doc/lsu_arbiter.md
Name:
lsu_arbiter

Overview:
- Two-requester arbiter in front of the shared load/store unit. Requester 0 is the core data port; requester 1 is the debug/loader port.
- Accepts one request per cycle when free and latches it. Drives the LSU for exactly one cycle, then returns a registered response to the owner.
- Also screens accesses: misaligned accesses and illegal funct3 values get an error response and never reach the LSU write path.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins.
- ADDR_W, 32: address width passed to the LSU.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- m0_req_i  in  1  requester 0 request; held with its fields until m0_gnt_o
- m0_we_i  in  1  1 = store, 0 = load
- m0_funct3_i  in  3  RV32 load/store funct3
- m0_addr_i  in  ADDR_W  byte address
- m0_wdata_i  in  32  store data
- m0_gnt_o  out  1  request accepted this cycle
- m0_rvalid_o  out  1  one-cycle response pulse
- m0_err_o  out  1  response is an error (valid with rvalid)
- m0_rdata_o  out  32  load data (valid with rvalid)
- m1_req_i, m1_we_i, m1_funct3_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_err_o, m1_rdata_o: same as m0, for requester 1
- lsu_wren_o  out  1  LSU write enable
- lsu_funct3_o  out  3  LSU funct3
- lsu_addr_o  out  ADDR_W  LSU address
- lsu_st_data_o  out  32  LSU store data
- lsu_ld_data_i  in  32  LSU combinational load data

Behaviour:
- Clocking and reset: single clock domain. The reset is asynchronous and active-low, on rst_ni.
- Reset state: state=IDLE, prio_q=0, owner_q=0.
- Reset values of all registered outputs and latched fields: rvalid=0, err=0, rdata=0, lsu_wren_o=0, lsu_funct3_o=0, lsu_addr_o=0, lsu_st_data_o=0.
- States:
  - IDLE: no transaction in flight.
  - ACCESS: LSU is driven from the latched request.
  - RESP: response presented to the owner.
- Accept condition: state is IDLE or RESP, and at least one req_i is high.
- Winner selection:
  - Only one requester high: that requester wins.
  - Both high, round-robin: winner = prio_q.
  - Both high, FIXED_PRIO=1: winner = 0.
- Accept actions:
  - gnt_o of the winner is asserted combinationally in the same cycle; gnt of the loser stays 0.
  - Winner fields and owner are latched at the clock edge; next state = ACCESS.
  - Round-robin only: prio_q <= ~winner.
- No acceptance in IDLE or RESP: next state = IDLE.
- ACCESS (exactly 1 cycle):
  - lsu_addr_o, lsu_funct3_o and lsu_st_data_o come from the latched fields.
  - lsu_wren_o = latched_we & ~err_det, and only in this state.
  - On the edge, rdata_q <= lsu_ld_data_i for a legal load; otherwise rdata_q <= 0.
  - err_q <= err_det. Next state = RESP.
- Error detect (err_det, computed on the latched fields):
  - Illegal funct3: 011, 110 or 111 is illegal for loads; any funct3 other than 000, 001 or 010 is illegal for stores.
  - Misaligned: word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
- RESP: rvalid_o=1 for the owner only, with err_o=err_q and rdata_o=rdata_q. Non-owner rvalid=0. A new request may be accepted in this same cycle.
- rdata_o and err_o of each port are don't-care when that port's rvalid=0; they are driven as 0.
- Latency and throughput: gnt cycle N, LSU access N+1, rvalid N+2. Back-to-back throughput is 1 access per 2 cycles.
- LSU fields hold their last latched values outside ACCESS, which keeps the LSU address stable; lsu_wren_o=0 outside ACCESS.
- Requester obligations: a requester must not change its fields while req is high and gnt is low. A requester may drop req without a grant; no grant results.
- Reset mid-operation: the in-flight transaction is dropped, no rvalid is issued, and no write occurs after rst_ni falls.

Decomposition:
- Package lsu_arb_pkg contains:
  - state enum {IDLE, ACCESS, RESP};
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - function is_access_err(we, funct3, addr[1:0]).
- Sub-module rr_arb2: 2-way winner picker with the prio register and FIXED_PRIO handling. It outputs winner and any_req.

Test Plan:
- Single store: m0 sw addr=0x2000, wdata=0xDEADBEEF -> m0_gnt in cycle 0; lsu_wren_o=1 for exactly cycle 1 with addr 0x2000; m0_rvalid=1 with err=0 in cycle 2.
- Load after store: m1 lw 0x2000 -> m1_rdata=0xDEADBEEF, err=0. Then lbu 0x2003 -> rdata=0x000000DE.
- Contention, round-robin: m0 and m1 both request continuously for 4 accesses -> grant order 0,1,0,1. Each gnt is 2 cycles apart, and rvalid goes only to the owner.
- FIXED_PRIO=1 with the same stimulus -> m0 granted every time; m1 is never granted while m0_req stays high.
- Errors:
  - m0 sw addr=0x2002 -> lsu_wren_o stays 0, m0_err=1, rdata=0, memory at 0x2000 unchanged.
  - funct3=011 load -> err=1.
- Reset: assert rst_ni low during ACCESS of a store -> no write, no rvalid, state IDLE, prio_q=0 after release.
